const_level_monitor: RTL and testbench



---
 rtl/const_level_monitor.sv | 148 ++++++++++++++
 tb/tb_const_level_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/const_level_monitor.sv
// ---------------------------------------------------------------------------
// const_level_monitor
//
// Watches a bus that a tie-off driver is supposed to hold at the constant
// level EXPECTED. When started, it checks a programmable number of
// consecutive cycles, counts the cycles where the bus differs from
// EXPECTED, and records where and with what value the first difference
// happened. At the end of the window it pulses done and reports pass/fail.
// The results stay visible until the next accepted start.
//
// Optional build macro:
//   CLM_ABORT_ON_ERR_EN - when defined, the first mismatch ends the window
//                         early. err_cnt then finishes at 1 and pass at 0.
//
// Parameters:
//   WIDTH     width of the monitored bus
//   EXPECTED  constant level that mon must hold
//   WIN_W     width of the window length and of the cycle index
//   CNT_W     width of the saturating mismatch counter
//
// Ports:
//   clk            rising-edge clock for all logic
//   rst_n          synchronous active-low reset
//   start          begin a check window; only looked at while idle
//   window         number of cycles to check; latched when start is accepted
//   mon            monitored bus, synchronous to clk
//   busy           high while a window is being checked
//   done           one-cycle pulse when a window completes
//   pass           1 when the last window saw no mismatches; held until restart
//   err_cnt        mismatch count of the last or current window
//   first_err_idx  window index of the first mismatch (0 if none)
//   first_err_val  mon value seen at the first mismatch (0 if none)
// ---------------------------------------------------------------------------
module const_level_monitor #(
   parameter int               WIDTH    = 1,
   parameter logic [WIDTH-1:0] EXPECTED = '0,
   parameter int               WIN_W    = 16,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIN_W-1:0] window,
   input  logic [WIDTH-1:0] mon,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIN_W-1:0] first_err_idx,
   output logic [WIDTH-1:0] first_err_val
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIN_W-1:0] win_len;
   logic [WIN_W-1:0] idx;

   logic             mismatch;
   logic             last_idx;
   logic             finish_now;
   logic [CNT_W-1:0] cnt_inc;

   // Per-cycle compare, saturating increment and end-of-window detection.
   // The count only ever grows from zero during a window, so err_cnt==0
   // is a reliable "no mismatch yet" flag for capturing the first one.
   always_comb begin
      mismatch = (mon != EXPECTED);
      last_idx = (idx == (win_len - WIN_W'(1)));
      cnt_inc  = (err_cnt == '1) ? err_cnt : (err_cnt + CNT_W'(1));
`ifdef CLM_ABORT_ON_ERR_EN
      finish_now = last_idx || mismatch;
`else
      finish_now = last_idx;
`endif
   end

   // Control FSM with registered outputs. done is raised on the edge that
   // enters DONE, so it is high for exactly the one cycle spent in DONE.
   // A zero-length window skips RUN and reports a trivial pass.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         win_len       <= '0;
         idx           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_cnt       <= '0;
         first_err_idx <= '0;
         first_err_val <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  err_cnt       <= '0;
                  first_err_idx <= '0;
                  first_err_val <= '0;
                  idx           <= '0;
                  if (window != '0) begin
                     win_len <= window;
                     pass    <= 1'b0;
                     busy    <= 1'b1;
                     state   <= RUN;
                  end else begin
                     pass  <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end

            RUN: begin
               if (mismatch) begin
                  err_cnt <= cnt_inc;
                  if (err_cnt == '0) begin
                     first_err_idx <= idx;
                     first_err_val <= mon;
                  end
               end
               if (finish_now) begin
                  pass  <= (err_cnt == '0) && !mismatch;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + WIN_W'(1);
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_const_level_monitor.sv
// ---------------------------------------------------------------------------
// tb_const_level_monitor
//
// Directed bench for const_level_monitor. Three instances are used:
//   u0  WIDTH=1, EXPECTED=0, CNT_W=16  (main behaviour)
//   u1  WIDTH=4, EXPECTED=4'hA         (multi-bit capture of the first error)
//   u2  WIDTH=1, CNT_W=2               (counter saturation)
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-derived constants; the abort build variant is
// selected with CLM_ABORT_ON_ERR_EN, just like the design.
// ---------------------------------------------------------------------------
module tb_const_level_monitor;

`ifdef CLM_ABORT_ON_ERR_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] win;
   logic        start0, start1, start2;
   logic        mon0;
   logic [3:0]  mon1;
   logic        mon2;

   logic        busy0, done0, pass0;
   logic [15:0] cnt0;
   logic [15:0] fidx0;
   logic        fval0;

   logic        busy1, done1, pass1;
   logic [15:0] cnt1;
   logic [15:0] fidx1;
   logic [3:0]  fval1;

   logic        busy2, done2, pass2;
   logic [1:0]  cnt2;
   logic [15:0] fidx2;
   logic        fval2;

   int checks = 0;
   int errors = 0;

   int lat;
   int ndone;

   always #5 clk = ~clk;

   const_level_monitor #(.WIDTH(1), .EXPECTED(1'b0), .WIN_W(16), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .window(win), .mon(mon0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(cnt0),
      .first_err_idx(fidx0), .first_err_val(fval0)
   );

   const_level_monitor #(.WIDTH(4), .EXPECTED(4'hA), .WIN_W(16), .CNT_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .window(win), .mon(mon1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(cnt1),
      .first_err_idx(fidx1), .first_err_val(fval1)
   );

   const_level_monitor #(.WIDTH(1), .EXPECTED(1'b0), .WIN_W(16), .CNT_W(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .window(win), .mon(mon2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(cnt2),
      .first_err_idx(fidx2), .first_err_val(fval2)
   );

   // Advance to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Run one window on u0. Bit j of mask is the mon value for window index j.
   // lat is the number of edges after the accepting edge until done is seen
   // (-1 if never), ndone counts done pulses. With poke set, a start pulse
   // and a window change are injected while the window is running.
   task automatic applyStimulus(input int w, input logic [31:0] mask, input bit poke,
                                output int lat_o, output int ndone_o);
      win    = 16'(w);
      start0 = 1'b1;
      mon0   = 1'b0;
      tick();
      start0  = 1'b0;
      lat_o   = -1;
      ndone_o = 0;
      checkOutput("busy_after_start", 32'(busy0), 32'(w != 0));
      for (int j = 0; j < w + 6; j++) begin
         if (done0) begin
            ndone_o++;
            if (lat_o < 0) lat_o = j;
         end
         mon0   = (j < 32) ? mask[j] : 1'b0;
         start0 = poke && (j == 2);
         if (poke) win = 16'd3;
         tick();
      end
      start0 = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      win    = '0;
      mon0   = 1'b0;
      mon1   = 4'hA;
      mon2   = 1'b0;
      tick();
      tick();

      // Reset values
      checkOutput("rst_busy", 32'(busy0), 32'd0);
      checkOutput("rst_done", 32'(done0), 32'd0);
      checkOutput("rst_pass", 32'(pass0), 32'd0);
      checkOutput("rst_cnt",  32'(cnt0),  32'd0);
      checkOutput("rst_fidx", 32'(fidx0), 32'd0);
      checkOutput("rst_fval", 32'(fval0), 32'd0);
      rst_n = 1'b1;
      tick();

      // Clean window of 10
      applyStimulus(10, 32'h0, 1'b0, lat, ndone);
      checkOutput("clean_lat",   32'(lat),   32'd10);
      checkOutput("clean_ndone", 32'(ndone), 32'd1);
      checkOutput("clean_pass",  32'(pass0), 32'd1);
      checkOutput("clean_cnt",   32'(cnt0),  32'd0);
      checkOutput("clean_fidx",  32'(fidx0), 32'd0);
      checkOutput("clean_fval",  32'(fval0), 32'd0);
      checkOutput("clean_busy",  32'(busy0), 32'd0);

      // Mismatches at indices 3 and 7
      applyStimulus(10, 32'h88, 1'b0, lat, ndone);
      checkOutput("two_lat",  32'(lat),   ABORT ? 32'd4 : 32'd10);
      checkOutput("two_pass", 32'(pass0), 32'd0);
      checkOutput("two_cnt",  32'(cnt0),  ABORT ? 32'd1 : 32'd2);
      checkOutput("two_fidx", 32'(fidx0), 32'd3);
      checkOutput("two_fval", 32'(fval0), 32'd1);

      // Results hold while idle
      mon0 = 1'b1;
      repeat (3) tick();
      checkOutput("hold_cnt",  32'(cnt0),  ABORT ? 32'd1 : 32'd2);
      checkOutput("hold_fidx", 32'(fidx0), 32'd3);
      checkOutput("hold_pass", 32'(pass0), 32'd0);

      // Zero-length window
      applyStimulus(0, 32'h0, 1'b0, lat, ndone);
      checkOutput("zero_lat",   32'(lat),   32'd0);
      checkOutput("zero_ndone", 32'(ndone), 32'd1);
      checkOutput("zero_pass",  32'(pass0), 32'd1);
      checkOutput("zero_cnt",   32'(cnt0),  32'd0);
      checkOutput("zero_fidx",  32'(fidx0), 32'd0);

      // Start pulse and window change during RUN are ignored
      applyStimulus(6, 32'h0, 1'b1, lat, ndone);
      checkOutput("poke_lat",   32'(lat),   32'd6);
      checkOutput("poke_ndone", 32'(ndone), 32'd1);
      checkOutput("poke_pass",  32'(pass0), 32'd1);

      // Window of 20 with a single mismatch at index 6
      applyStimulus(20, 32'h40, 1'b0, lat, ndone);
      checkOutput("w20_lat",  32'(lat),   ABORT ? 32'd7 : 32'd20);
      checkOutput("w20_cnt",  32'(cnt0),  32'd1);
      checkOutput("w20_pass", 32'(pass0), 32'd0);
      checkOutput("w20_fidx", 32'(fidx0), 32'd6);
      checkOutput("w20_fval", 32'(fval0), 32'd1);

      // Reset while checking index 4 aborts without a done pulse
      win    = 16'd10;
      start0 = 1'b1;
      mon0   = 1'b0;
      tick();
      start0 = 1'b0;
      for (int j = 0; j < 4; j++) begin
         mon0 = !ABORT && (j == 1);
         tick();
      end
      checkOutput("pre_rst_busy", 32'(busy0), 32'd1);
      checkOutput("pre_rst_cnt",  32'(cnt0),  ABORT ? 32'd0 : 32'd1);
      rst_n = 1'b0;
      mon0  = 1'b1;
      tick();
      checkOutput("mid_rst_busy", 32'(busy0), 32'd0);
      checkOutput("mid_rst_done", 32'(done0), 32'd0);
      checkOutput("mid_rst_cnt",  32'(cnt0),  32'd0);
      checkOutput("mid_rst_fidx", 32'(fidx0), 32'd0);
      checkOutput("mid_rst_fval", 32'(fval0), 32'd0);
      rst_n = 1'b1;
      mon0  = 1'b0;
      ndone = 0;
      repeat (12) begin
         if (done0) ndone++;
         tick();
      end
      checkOutput("mid_rst_nodone", 32'(ndone), 32'd0);

      // u1: 4-bit bus, EXPECTED=A, wrong value 3 at index 0
      win    = 16'd5;
      start1 = 1'b1;
      mon1   = 4'hA;
      tick();
      start1 = 1'b0;
      lat    = -1;
      for (int j = 0; j < 10; j++) begin
         if (done1 && lat < 0) lat = j;
         mon1 = (j == 0) ? 4'h3 : 4'hA;
         tick();
      end
      checkOutput("w4_lat",  32'(lat),   ABORT ? 32'd1 : 32'd5);
      checkOutput("w4_cnt",  32'(cnt1),  32'd1);
      checkOutput("w4_fidx", 32'(fidx1), 32'd0);
      checkOutput("w4_fval", 32'(fval1), 32'h3);
      checkOutput("w4_pass", 32'(pass1), 32'd0);

      // u2: 2-bit counter saturates at 3 with mon always wrong
      win    = 16'd8;
      start2 = 1'b1;
      mon2   = 1'b1;
      tick();
      start2 = 1'b0;
      lat    = -1;
      for (int j = 0; j < 12; j++) begin
         if (done2 && lat < 0) lat = j;
         tick();
      end
      checkOutput("sat_lat",  32'(lat),   ABORT ? 32'd1 : 32'd8);
      checkOutput("sat_cnt",  32'(cnt2),  ABORT ? 32'd1 : 32'd3);
      checkOutput("sat_pass", 32'(pass2), 32'd0);
      checkOutput("sat_fidx", 32'(fidx2), 32'd0);
      checkOutput("sat_fval", 32'(fval2), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
